// File: rtl/noc_rx_interface.sv
// NoC receive interface: reassembles head/body/tail flits into a packet and holds it for the
// consumer, flagging protocol errors with a strobe, a sticky cause code and counters.
module noc_rx_interface #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned TYPE_WIDTH    = 2,
    parameter int unsigned FlitPerPacket = 6,
    localparam int unsigned PW           = DATA_WIDTH - TYPE_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        valid_in,
    output logic                        ready_in,
    output logic [FlitPerPacket*PW-1:0] pkt_data,
    output logic                        pkt_valid,
    input  logic                        pkt_ready,
    output logic                        err_pulse,
    output logic [2:0]                  err_code,
    output logic [15:0]                 pkt_count,
    output logic [7:0]                  err_count
);

    localparam int unsigned IW = $clog2(FlitPerPacket);
    localparam logic [IW-1:0] LastIdx = IW'(FlitPerPacket - 1);

    localparam logic [TYPE_WIDTH-1:0] TypeHead = TYPE_WIDTH'(1);
    localparam logic [TYPE_WIDTH-1:0] TypeBody = TYPE_WIDTH'(2);
    localparam logic [TYPE_WIDTH-1:0] TypeTail = TYPE_WIDTH'(3);

    localparam logic [2:0] ErrNoHead  = 3'd1;
    localparam logic [2:0] ErrReHead  = 3'd2;
    localparam logic [2:0] ErrShort   = 3'd3;
    localparam logic [2:0] ErrLong    = 3'd4;
    localparam logic [2:0] ErrIllegal = 3'd5;

    typedef enum logic [1:0] {StIdle, StCollect, StHold} state_e;

    state_e                      state_q, state_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [FlitPerPacket*PW-1:0] data_q, data_d;
    logic                        err_pulse_q, err_pulse_d;
    logic [2:0]                  err_code_q, err_code_d;
    logic [15:0]                 pkt_count_q, pkt_count_d;
    logic [7:0]                  err_count_q, err_count_d;

    logic [TYPE_WIDTH-1:0] flit_type;
    logic [PW-1:0]         payload;
    logic                  accept;
    logic                  err_hit;
    logic [2:0]            err_val;

    assign flit_type = data_in[DATA_WIDTH-1 -: TYPE_WIDTH];
    assign payload   = data_in[PW-1:0];
    assign accept    = valid_in && (state_q != StHold);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            data_q      <= '0;
            err_pulse_q <= 1'b0;
            err_code_q  <= '0;
            pkt_count_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            pkt_count_q <= pkt_count_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        data_d      = data_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        pkt_count_d = pkt_count_q;
        err_count_d = err_count_q;
        err_hit     = 1'b0;
        err_val     = '0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (flit_type == TypeHead) begin
                        data_d[PW-1:0] = payload;
                        idx_d          = IW'(1);
                        state_d        = StCollect;
                    end else if (flit_type == TypeBody || flit_type == TypeTail) begin
                        err_hit = 1'b1;
                        err_val = ErrNoHead;
                    end else begin
                        err_hit = 1'b1;
                        err_val = ErrIllegal;
                    end
                end
            end
            StCollect: begin
                if (accept) begin
                    if (flit_type == TypeHead) begin
                        // Abandon the partial packet and restart from this head.
                        data_d[PW-1:0] = payload;
                        idx_d          = IW'(1);
                        err_hit        = 1'b1;
                        err_val        = ErrReHead;
                    end else if (flit_type == TypeBody) begin
                        if (idx_q < LastIdx) begin
                            data_d[idx_q*PW +: PW] = payload;
                            idx_d                  = idx_q + IW'(1);
                        end else begin
                            idx_d   = '0;
                            state_d = StIdle;
                            err_hit = 1'b1;
                            err_val = ErrLong;
                        end
                    end else if (flit_type == TypeTail) begin
                        if (idx_q == LastIdx) begin
                            data_d[idx_q*PW +: PW] = payload;
                            state_d                = StHold;
                        end else begin
                            idx_d   = '0;
                            state_d = StIdle;
                            err_hit = 1'b1;
                            err_val = ErrShort;
                        end
                    end else begin
                        err_hit = 1'b1;
                        err_val = ErrIllegal;
                    end
                end
            end
            StHold: begin
                if (pkt_ready) begin
                    idx_d       = '0;
                    state_d     = StIdle;
                    pkt_count_d = pkt_count_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (err_hit) begin
            err_pulse_d = 1'b1;
            err_code_d  = err_val;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    // rst gates ready_in so no flit is offered a handshake while the block is held in reset.
    always_comb begin
        ready_in  = rst && (state_q != StHold);
        pkt_valid = (state_q == StHold);
    end

    assign pkt_data  = data_q;
    assign err_pulse = err_pulse_q;
    assign err_code  = err_code_q;
    assign pkt_count = pkt_count_q;
    assign err_count = err_count_q;

endmodule

// File: doc/noc_rx_interface.md
NOC_RX_INTERFACE -- requirements
Module: noc_rx_interface

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, flit width in bits.
REQ-002 SHALL have parameter TYPE_WIDTH, default 2, flit type field width, located at flit bits [DATA_WIDTH-1 : DATA_WIDTH-TYPE_WIDTH].
REQ-003 SHALL have parameter FlitPerPacket, default 6, flits per packet: head, FlitPerPacket-2 bodies, tail.
REQ-004 SHALL have derived parameter PW = DATA_WIDTH-TYPE_WIDTH, the payload bits per flit.
REQ-005 Clocking and reset SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  sole clock; all state changes on posedge.
REQ-007 rst  input  1  asynchronous, active-low reset (0 = in reset).
REQ-008 data_in  input  DATA_WIDTH  flit from the router output port.
REQ-009 valid_in  input  1  flit on data_in is valid.
REQ-010 ready_in  output  1  interface accepts a flit; transfer occurs when valid_in and ready_in are both 1 at posedge.
REQ-011 pkt_data  output  FlitPerPacket*PW  reassembled packet; flit k (head = 0) payload at bits [k*PW +: PW].
REQ-012 pkt_valid  output  1  pkt_data holds a complete packet.
REQ-013 pkt_ready  input  1  consumer accepts the packet.
REQ-014 err_pulse  output  1  one-cycle protocol-error strobe.
REQ-015 err_code  output  3  cause of the last error; holds until the next error.
REQ-016 pkt_count  output  16  number of delivered packets.
REQ-017 err_count  output  8  number of errors.

Function
REQ-018 Flit type codes SHALL be: 1 = head, 2 = body, 3 = tail, 0 = illegal.
REQ-019 The block SHALL implement an FSM with states IDLE (expect head), COLLECT (expect body or tail), and HOLD (packet presented).
REQ-020 ready_in SHALL be 1 in IDLE and COLLECT, 0 in HOLD, and SHALL be decoded from registered state only.
REQ-021 In IDLE, an accepted head SHALL store its payload into slot 0, set flit index to 1, and move to COLLECT.
REQ-022 In COLLECT, an accepted body with index < FlitPerPacket-1 SHALL store into slot index and increment the index.
REQ-023 In COLLECT, an accepted tail with index == FlitPerPacket-1 SHALL store into the last slot and move to HOLD; pkt_valid SHALL be 1 in the cycle after the tail handshake.
REQ-024 In HOLD, pkt_valid SHALL be 1 and pkt_data SHALL be stable until pkt_valid and pkt_ready are both 1 at a posedge.
REQ-025 On that HOLD handshake, the FSM SHALL move to IDLE and pkt_count SHALL increment, wrapping 0xFFFF to 0; ready_in SHALL be 1 in the next cycle.
REQ-026 pkt_ready while not in HOLD SHALL be ignored.
REQ-027 Error: body or tail accepted in IDLE -> flit dropped, err_code 1, stay IDLE.
REQ-028 Error: head accepted in COLLECT -> err_code 2, partial packet discarded, new packet started with this head (index = 1), stay COLLECT.
REQ-029 Error: tail accepted in COLLECT with index < FlitPerPacket-1 -> err_code 3 (short packet), discard, go IDLE.
REQ-030 Error: body accepted in COLLECT with index == FlitPerPacket-1 -> err_code 4 (long packet), discard, go IDLE.
REQ-031 Error: type 0 accepted in any state -> err_code 5, flit dropped, state and index unchanged.
REQ-032 Each error SHALL assert err_pulse in the cycle after the offending handshake and SHALL increment err_count, saturating at 255.
REQ-033 Flits with valid_in = 0 SHALL have no effect, including in HOLD.

Reset
REQ-034 When rst = 0, the block SHALL asynchronously force state IDLE, index 0, pkt_data 0, pkt_valid 0, err_pulse 0, err_code 0, pkt_count 0, and err_count 0.
REQ-035 ready_in SHALL be 0 while rst = 0 and SHALL be 1 in the first cycle after rst deasserts.
REQ-036 Reset asserted mid-packet or in HOLD SHALL discard the packet without delivery and without error.

Verification
REQ-037 Reset release, then flits 0x40000001, 0x80000002..0x80000005, 0xC0000006 back-to-back -> pkt_valid = 1 one cycle after the tail, slot k = k+1, ready_in = 0; pulse pkt_ready -> pkt_count = 1, ready_in = 1.
REQ-038 Packet delivered with pkt_ready held 0 for 10 cycles while valid_in = 1 -> ready_in stays 0, pkt_data stable, no flit consumed; consumption resumes after the handshake.
REQ-039 Body flit 0x80000007 sent in IDLE -> err_pulse one cycle, err_code = 1, err_count = 1; a following good packet is delivered intact.
REQ-040 Head, two bodies, tail -> err_code = 3 and no pkt_valid; head, 2 bodies, then a new head plus a full packet -> err_code = 2 and the second packet is delivered.
REQ-041 Type-0 flit mid-packet -> err_code = 5 and the packet still completes; 300 errors -> err_count = 255.
REQ-042 rst pulsed low asynchronously between posedges after 3 flits -> outputs zero immediately; a subsequent full packet is delivered with pkt_count = 1.
